// File: rtl/kmap_pkg.sv
// Shared types and limits for the K-map sweep sequencer.
package kmap_pkg;

  localparam int unsigned KMAP_MAX_VARS   = 5;
  localparam int unsigned KMAP_MAX_SETTLE = 15;
  localparam int unsigned KMAP_SETTLE_W   = $clog2(KMAP_MAX_SETTLE + 1);

  typedef enum logic [1:0] {
    StIdle,
    StApply,
    StSample,
    StDone
  } kmap_state_e;

endpackage

// File: rtl/kmap_minterm_cnt.sv
// Minterm index and settle counters for the sweep sequencer.
// The settle counter runs 0..SETTLE_CYCLES-1 during APPLY; the value SETTLE_CYCLES
// marks the SAMPLE slot, after which the index advances and the settle count wraps.
module kmap_minterm_cnt
  import kmap_pkg::*;
#(
  parameter int unsigned NUM_VARS      = 5,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clr_i,
  input  logic                en_i,
  input  logic                abort_i,
  output logic [NUM_VARS-1:0] idx_o,
  output logic                settle_done_o,
  output logic                last_o
);

  localparam logic [KMAP_SETTLE_W-1:0] SettleLast = KMAP_SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [KMAP_SETTLE_W-1:0] SampleSlot = KMAP_SETTLE_W'(SETTLE_CYCLES);
  localparam logic [NUM_VARS-1:0]      IdxLast    = '1;

  logic [NUM_VARS-1:0]      idx_q, idx_d;
  logic [KMAP_SETTLE_W-1:0] settle_q, settle_d;

  // Next-state: clear/abort reset both counters, otherwise step while enabled.
  always_comb begin
    idx_d    = idx_q;
    settle_d = settle_q;
    if (clr_i || abort_i) begin
      idx_d    = '0;
      settle_d = '0;
    end else if (en_i) begin
      if (settle_q == SampleSlot) begin
        settle_d = '0;
        idx_d    = idx_q + 1'b1;  // wraps to 0 after the last minterm
      end else begin
        settle_d = settle_q + 1'b1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q    <= '0;
      settle_q <= '0;
    end else begin
      idx_q    <= idx_d;
      settle_q <= settle_d;
    end
  end

  assign idx_o         = idx_q;
  assign settle_done_o = (settle_q == SettleLast);
  assign last_o        = (idx_q == IdxLast);

endmodule

// File: rtl/kmap_sweep_ctrl.sv
// Exhaustive K-map sweep sequencer: steps vars through all minterms, captures f_in into
// truth_table. Optional golden compare is built when KMAP_SWEEP_COMPARE_EN is defined;
// otherwise mismatch_cnt and pass are tied to 0.
module kmap_sweep_ctrl
  import kmap_pkg::*;
#(
  parameter int unsigned NUM_VARS      = 5,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        abort,
  output logic [NUM_VARS-1:0]         vars,
  input  logic                        f_in,
  input  logic [(1<<NUM_VARS)-1:0]    golden,
  output logic                        busy,
  output logic                        done,
  output logic [(1<<NUM_VARS)-1:0]    truth_table,
  output logic [NUM_VARS:0]           mismatch_cnt,
  output logic                        pass
);

  localparam int unsigned NumMin = 1 << NUM_VARS;

  kmap_state_e             state_q, state_d;
  logic [NumMin-1:0]       tt_q, tt_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [NUM_VARS-1:0]     idx;
  logic                    settle_done, last;
  logic                    cnt_clr, cnt_en;
  logic                    accept, capture;

  assign accept  = (state_q == StIdle) && start && !abort;
  assign capture = (state_q == StSample) && !abort;

  kmap_minterm_cnt #(
    .NUM_VARS     (NUM_VARS),
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_cnt (
    .clk_i        (clk),
    .rst_i        (rst),
    .clr_i        (cnt_clr),
    .en_i         (cnt_en),
    .abort_i      (abort),
    .idx_o        (idx),
    .settle_done_o(settle_done),
    .last_o       (last)
  );

  // FSM next-state, counter control and capture.
  always_comb begin
    state_d = state_q;
    tt_d    = tt_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StApply;
          cnt_clr = 1'b1;
          tt_d    = '0;
        end
      end
      StApply: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          cnt_en = 1'b1;
          if (settle_done) state_d = StSample;
        end
      end
      StSample: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          cnt_en    = 1'b1;
          tt_d[idx] = f_in;
          state_d   = last ? StDone : StApply;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    busy_d = (state_d == StApply) || (state_d == StSample);
    done_d = (state_d == StDone);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      tt_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tt_q    <= tt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // The index counter returns to 0 on abort and after the last minterm, so it drives vars.
  assign vars        = idx;
  assign busy        = busy_q;
  assign done        = done_q;
  assign truth_table = tt_q;

`ifdef KMAP_SWEEP_COMPARE_EN
  logic [NUM_VARS:0] mm_q, mm_d;
  logic              pass_q, pass_d;

  // Mismatch counting during capture; pass verdict taken in DONE.
  always_comb begin
    mm_d   = mm_q;
    pass_d = pass_q;
    if (accept) begin
      mm_d   = '0;
      pass_d = 1'b0;
    end else if (capture && (f_in != golden[idx])) begin
      mm_d = mm_q + 1'b1;
    end else if (state_q == StDone) begin
      pass_d = (mm_q == '0);
    end
  end

  // Compare registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mm_q   <= '0;
      pass_q <= 1'b0;
    end else begin
      mm_q   <= mm_d;
      pass_q <= pass_d;
    end
  end

  assign mismatch_cnt = mm_q;
  assign pass         = pass_q;
`else
  logic unused_golden;
  logic unused_capture;
  assign unused_golden  = ^golden;
  assign unused_capture = capture;
  assign mismatch_cnt   = '0;
  assign pass           = 1'b0;
`endif

endmodule

// File: tb/tb_kmap_sweep_ctrl.sv
// Self-checking bench for kmap_sweep_ctrl: one 4-variable/settle-1 instance and one
// 5-variable/settle-3 instance, selected by use5; expectations come from a truth-table model.
module tb_kmap_sweep_ctrl;

`ifdef KMAP_SWEEP_COMPARE_EN
  localparam bit CmpEn = 1'b1;
`else
  localparam bit CmpEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, start, abort;
  bit          use5;
  logic [31:0] fn, golden;

  logic [3:0]  vars4;
  logic [4:0]  vars5;
  logic        busy4, busy5, done4, done5, pass4, pass5;
  logic [15:0] tt4;
  logic [31:0] tt5;
  logic [4:0]  mm4;
  logic [5:0]  mm5;

  logic [31:0] o_vars, o_tt;
  logic [5:0]  o_mm;
  logic        o_busy, o_done, o_pass;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  kmap_sweep_ctrl #(.NUM_VARS(4), .SETTLE_CYCLES(1)) u_dut4 (
    .clk(clk), .rst(rst), .start(start & ~use5), .abort(abort & ~use5), .vars(vars4),
    .f_in(fn[vars4]), .golden(golden[15:0]), .busy(busy4), .done(done4),
    .truth_table(tt4), .mismatch_cnt(mm4), .pass(pass4)
  );

  kmap_sweep_ctrl #(.NUM_VARS(5), .SETTLE_CYCLES(3)) u_dut5 (
    .clk(clk), .rst(rst), .start(start & use5), .abort(abort & use5), .vars(vars5),
    .f_in(fn[vars5]), .golden(golden), .busy(busy5), .done(done5),
    .truth_table(tt5), .mismatch_cnt(mm5), .pass(pass5)
  );

  always_comb begin
    if (use5) begin
      o_vars = 32'(vars5); o_tt = tt5; o_mm = mm5;
      o_busy = busy5; o_done = done5; o_pass = pass5;
    end else begin
      o_vars = 32'(vars4); o_tt = 32'(tt4); o_mm = 6'(mm4);
      o_busy = busy4; o_done = done4; o_pass = pass4;
    end
  end

  // Full sweep with the model: vars = k/(S+1) while busy, done at 2^N*(S+1), then pass.
  // Start is re-pulsed during cycles pa and pb (ignored while busy).
  task automatic run_sweep(input logic [31:0] f, input logic [31:0] g, input int pa,
                           input int pb, input string name);
    int s, n, per, tot, dones, exp_mm;
    logic [31:0] mask, exp_tt;
    bit exp_pass;
    s = use5 ? 3 : 1;
    n = use5 ? 32 : 16;
    per = s + 1;
    tot = n * per;
    mask = use5 ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    fn = f;
    golden = g;
    exp_tt = f & mask;
    exp_mm = CmpEn ? $countones((f ^ g) & mask) : 0;
    exp_pass = CmpEn && (exp_mm == 0);
    dones = 0;
    start = 1'b1;
    for (int k = 0; k <= tot + 1; k++) begin
      @(negedge clk);
      start = (k == pa) || (k == pb);
      if (o_done) dones++;
      if (k < tot) begin
        total++;
        if (o_vars !== 32'(k / per)) begin
          bad++; $display("FAIL %s vars cycle %0d: got %0d want %0d", name, k, o_vars, k / per);
        end
        total++;
        if (o_busy !== 1'b1) begin
          bad++; $display("FAIL %s busy cycle %0d: got %b want 1", name, k, o_busy);
        end
      end else if (k == tot) begin
        total++;
        if (o_done !== 1'b1 || o_busy !== 1'b0) begin
          bad++; $display("FAIL %s done/busy cycle %0d: got %b/%b want 1/0", name, k, o_done,
                          o_busy);
        end
        total++;
        if (o_tt !== exp_tt) begin
          bad++; $display("FAIL %s truth_table: got %h want %h", name, o_tt, exp_tt);
        end
        total++;
        if (o_mm !== 6'(exp_mm)) begin
          bad++; $display("FAIL %s mismatch_cnt: got %0d want %0d", name, o_mm, exp_mm);
        end
      end else begin
        total++;
        if (o_pass !== exp_pass || o_done !== 1'b0) begin
          bad++; $display("FAIL %s pass/done: got %b/%b want %b/0", name, o_pass, o_done,
                          exp_pass);
        end
      end
    end
    total++;
    if (dones != 1) begin
      bad++; $display("FAIL %s done pulses: got %0d want 1", name, dones);
    end
  endtask

  task automatic test_reset();
    total++;
    if ({vars4, busy4, done4, tt4, mm4, pass4} !== '0 ||
        {vars5, busy5, done5, tt5, mm5, pass5} !== '0) begin
      bad++; $display("FAIL reset values: got 4v=%h/%h 5v=%h/%h want all 0",
                      {vars4, busy4, done4, mm4, pass4}, tt4, {vars5, busy5, done5, mm5, pass5},
                      tt5);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_plan4();
    logic [31:0] f_ab;
    use5 = 1'b0;
    f_ab = '0;
    for (int i = 0; i < 16; i++) f_ab[i] = i[3] & i[2];
    run_sweep(f_ab, 32'h0000_F000, -1, -1, "and_ab");
    run_sweep(f_ab, 32'h0000_F001, -1, -1, "and_ab_g1");
    run_sweep(32'h0000_FFFF, 32'h0, -1, -1, "f_one");
  endtask

  task automatic test_plan5();
    logic [31:0] f_ae;
    use5 = 1'b1;
    for (int i = 0; i < 32; i++) f_ae[i] = i[4] ^ i[0];
    run_sweep(f_ae, f_ae, -1, -1, "xor_ae");
  endtask

  task automatic test_random();
    logic [31:0] f, g;
    for (int r = 0; r < 6; r++) begin
      use5 = r[0];
      f = $urandom;
      g = ($urandom_range(0, 2) == 0) ? f : (f ^ ($urandom & $urandom));
      run_sweep(f, g, -1, -1, "random");
    end
  endtask

  task automatic test_start_ignored();
    use5 = 1'b0;
    run_sweep($urandom, $urandom, 5, 20, "start_busy");
  endtask

  task automatic test_back_to_back();
    use5 = 1'b0;
    run_sweep($urandom, 32'h0, -1, -1, "b2b_first");
    run_sweep($urandom, 32'h0, -1, -1, "b2b_second");
  endtask

  task automatic test_start_abort_idle();
    use5 = 1'b0;
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    total++;
    if (o_busy !== 1'b0 || o_vars !== 32'h0) begin
      bad++; $display("FAIL start_abort_idle: got busy=%b vars=%0d want 0/0", o_busy, o_vars);
    end
  endtask

  // Abort in APPLY (cycle 10) and in SAMPLE (cycle 11): only minterms 0..4 captured.
  task automatic test_abort();
    logic [31:0] f, g;
    int dones, exp_mm;
    use5 = 1'b0;
    for (int ab = 10; ab <= 11; ab++) begin
      f = $urandom | 32'h20;
      g = $urandom;
      fn = f;
      golden = g;
      exp_mm = CmpEn ? $countones((f ^ g) & 32'h1F) : 0;
      dones = 0;
      @(negedge clk);
      start = 1'b1;
      for (int k = 0; k <= ab + 4; k++) begin
        @(negedge clk);
        start = 1'b0;
        abort = (k == ab);
        if (o_done) dones++;
        if (k == ab) begin
          total++;
          if (o_busy !== 1'b1) begin
            bad++; $display("FAIL abort busy before edge: got %b want 1", o_busy);
          end
        end else if (k == ab + 1) begin
          total++;
          if (o_busy !== 1'b0 || o_vars !== 32'h0) begin
            bad++; $display("FAIL abort idle: got busy=%b vars=%0d want 0/0", o_busy, o_vars);
          end
          total++;
          if (o_tt !== (f & 32'h1F)) begin
            bad++; $display("FAIL abort partial tt: got %h want %h", o_tt, f & 32'h1F);
          end
          total++;
          if (o_mm !== 6'(exp_mm)) begin
            bad++; $display("FAIL abort mismatch_cnt: got %0d want %0d", o_mm, exp_mm);
          end
        end
      end
      abort = 1'b0;
      total++;
      if (dones != 0) begin
        bad++; $display("FAIL abort done pulses: got %0d want 0", dones);
      end
    end
    run_sweep($urandom, $urandom, -1, -1, "after_abort");
  endtask

  task automatic test_reset_mid();
    logic [31:0] f_ab;
    use5 = 1'b0;
    fn = 32'h0000_FFFF;
    @(negedge clk);
    start = 1'b1;
    for (int k = 0; k <= 7; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({o_vars, o_busy, o_done, o_tt, o_mm, o_pass} !== '0) begin
      bad++; $display("FAIL reset_mid: got vars=%0d busy=%b done=%b tt=%h mm=%0d pass=%b want 0",
                      o_vars, o_busy, o_done, o_tt, o_mm, o_pass);
    end
    @(negedge clk);
    rst = 1'b0;
    f_ab = '0;
    for (int i = 0; i < 16; i++) f_ab[i] = i[3] & i[2];
    run_sweep(f_ab, 32'h0000_F000, -1, -1, "after_reset");
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    use5 = 1'b0;
    fn = '0;
    golden = '0;
    #12;
    test_reset();
    test_plan4();
    test_plan5();
    test_start_ignored();
    test_back_to_back();
    test_start_abort_idle();
    test_abort();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
